// File: rtl/spawn_pos_gen.sv
// Pseudo-random on-screen spawn position generator: two free-running LFSRs
// are sampled until a point falls inside the X_MAX x Y_MAX field, with a masked fallback.
module spawn_pos_gen #(
    parameter int unsigned X_MAX     = 640,
    parameter int unsigned Y_MAX     = 480,
    parameter int unsigned MAX_TRIES = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] seed_x,
    input  logic [8:0] seed_y,
    input  logic       req,
    input  logic       ack,
    output logic       valid,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       busy
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned TW = 4;

    localparam logic [XW:0]   X_LIM    = (XW+1)'(X_MAX);
    localparam logic [YW:0]   Y_LIM    = (YW+1)'(Y_MAX);
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [TW-1:0]   try_cnt;
    logic [TW-1:0]   try_d;
    logic [XW-1:0]   lfsr_x;
    logic [YW-1:0]   lfsr_y;
    logic [XW-1:0]   seed_x_nz;
    logic [YW-1:0]   seed_y_nz;
    logic [XW-1:0]   pos_x_d;
    logic [YW-1:0]   pos_y_d;
    logic            valid_d;
    logic            busy_d;
    logic            accept;

    // An all-zero seed would freeze an LFSR, so it is replaced by 1.
    assign seed_x_nz = (seed_x == '0) ? XW'(1) : seed_x;
    assign seed_y_nz = (seed_y == '0) ? YW'(1) : seed_y;

    assign accept = ({1'b0, lfsr_x} < X_LIM) && ({1'b0, lfsr_y} < Y_LIM);

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        try_d   = try_cnt;
        valid_d = valid;
        pos_x_d = pos_x;
        pos_y_d = pos_y;

        case (state)
            IDLE: begin
                if (req) begin
                    state_d = SEARCH;
                    try_d   = '0;
                end
            end
            SEARCH: begin
                if (accept) begin
                    pos_x_d = lfsr_x;
                    pos_y_d = lfsr_y;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (try_cnt == LAST_TRY) begin
                    // Out of tries: drop the top bit of each coordinate to force it in range.
                    pos_x_d = {1'b0, lfsr_x[XW-2:0]};
                    pos_y_d = {1'b0, lfsr_y[YW-2:0]};
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    try_d = try_cnt + TW'(1);
                end
            end
            DONE: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Datapath registers; the LFSRs step every cycle regardless of state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            try_cnt <= '0;
            lfsr_x  <= seed_x_nz;
            lfsr_y  <= seed_y_nz;
            pos_x   <= '0;
            pos_y   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            try_cnt <= try_d;
            lfsr_x  <= {lfsr_x[0] ^ lfsr_x[3], lfsr_x[XW-1:1]};
            lfsr_y  <= {lfsr_y[YW-1] ^ lfsr_y[0], lfsr_y[YW-1:1]};
            pos_x   <= pos_x_d;
            pos_y   <= pos_y_d;
            valid   <= valid_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_spawn_pos_gen.sv
// Scoreboard bench for spawn_pos_gen: directed seeds with hand-derived positions,
// async abort, and a long back-to-back run checked against the field bounds.
module tb_spawn_pos_gen;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [9:0] seed_x = '0;
    logic [8:0] seed_y = '0;
    logic [8:0] seed_y1 = '0;
    logic       req = 1'b0;
    logic       ack = 1'b0;
    logic       req1 = 1'b0;
    logic       ack1 = 1'b0;
    logic       valid, busy, valid1, busy1;
    logic [9:0] pos_x, pos_x1;
    logic [8:0] pos_y, pos_y1;

    typedef struct {
        int x;
        int y;
    } pos_t;

    pos_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   accepted = 0;
    int   viol = 0;
    bit   rand_mode = 1'b0;
    logic valid_q = 1'b0;

    always #5 clk = ~clk;

    spawn_pos_gen u_dut (
        .clk(clk), .clr(clr), .seed_x(seed_x), .seed_y(seed_y),
        .req(req), .ack(ack), .valid(valid), .pos_x(pos_x), .pos_y(pos_y), .busy(busy)
    );

    spawn_pos_gen #(.MAX_TRIES(1)) u_dut1 (
        .clk(clk), .clr(clr), .seed_x(seed_x), .seed_y(seed_y1),
        .req(req1), .ack(ack1), .valid(valid1), .pos_x(pos_x1), .pos_y(pos_y1), .busy(busy1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [9:0] sx, input logic [8:0] sy, input logic [8:0] sy1);
        tick();
        clr = 1'b1; seed_x = sx; seed_y = sy; seed_y1 = sy1;
        req = 1'b0; ack = 1'b0; req1 = 1'b0; ack1 = 1'b0;
        #1;
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pos", int'(pos_x) + int'(pos_y), 0);
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n = 0;
        while (!valid && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, int'(valid), 1);
    endtask

    task automatic ack_pulse(input string name);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({name, "_ack_valid"}, int'(valid), 0);
        check({name, "_ack_busy"}, int'(busy), 0);
    endtask

    // Monitor: every fresh valid is matched against the scoreboard or the field bounds.
    always @(negedge clk) begin
        pos_t e;
        if (valid && !busy) viol++;
        if (valid && !valid_q) begin
            if (rand_mode) begin
                accepted++;
                check("rand_x_in_field", int'(pos_x < 10'd640), 1);
                check("rand_y_in_field", int'(pos_y < 9'd480), 1);
            end else if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_pos_x", int'(pos_x), e.x);
                check("sb_pos_y", int'(pos_y), e.y);
            end
        end
        valid_q = valid;
    end

    initial begin
        // Seeds 5/3: accept on second edge at (514,257); fallback instance sees (514,504).
        do_reset(10'd5, 9'd3, 9'h1F0);
        exp_q.push_back('{514, 257});
        req = 1'b1; req1 = 1'b1;
        tick();
        req = 1'b0; req1 = 1'b0;
        check("t1_e1_busy", int'(busy), 1);
        check("t1_e1_valid", int'(valid), 0);
        check("t1_e1_lfsr_x", int'(u_dut.lfsr_x), 514);
        tick();
        check("t1_e2_valid", int'(valid), 1);
        check("t1_e2_busy", int'(busy), 1);
        check("fb_valid", int'(valid1), 1);
        check("fb_pos_x", int'(pos_x1), 2);
        check("fb_pos_y", int'(pos_y1), 248);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", int'(valid), 1);
            check("hold_pos_x", int'(pos_x), 514);
            check("hold_pos_y", int'(pos_y), 257);
        end
        ack_pulse("t1");

        // Zero y seed is replaced by 1, then steps to 256.
        do_reset(10'd5, 9'd0, 9'd1);
        check("zseed_y_rst", int'(u_dut.lfsr_y), 1);
        exp_q.push_back('{514, 256});
        req = 1'b1;
        tick();
        req = 1'b0;
        check("zseed_y_e1", int'(u_dut.lfsr_y), 256);
        wait_valid("t2_valid", 20);
        ack_pulse("t2");

        // Zero x seed -> 1 -> 512.
        do_reset(10'd0, 9'd3, 9'd1);
        exp_q.push_back('{512, 257});
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_valid("t3_valid", 20);
        ack_pulse("t3");

        // Seed 769: (896,257) rejected, then (448,128) accepted on edge 3.
        do_reset(10'd769, 9'd3, 9'd1);
        exp_q.push_back('{448, 128});
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        check("t4_e2_valid", int'(valid), 0);
        check("t4_e2_busy", int'(busy), 1);
        tick();
        check("t4_e3_valid", int'(valid), 1);
        ack_pulse("t4");

        // Async abort mid-search: outputs clear at once, no valid afterwards.
        do_reset(10'd769, 9'd3, 9'd1);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("t5_in_search", int'(busy), 1);
        #2 clr = 1'b1;
        #1;
        check("abort_valid", int'(valid), 0);
        check("abort_pos_x", int'(pos_x), 0);
        check("abort_pos_y", int'(pos_y), 0);
        check("abort_busy", int'(busy), 0);
        #1 clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_valid", int'(valid), 0);
        check("abort_idle", int'(busy), 0);

        // Back-to-back requests with ack held high.
        do_reset(10'd5, 9'd3, 9'd1);
        rand_mode = 1'b1;
        ack = 1'b1;
        req = 1'b1;
        begin
            int cyc = 0;
            while (accepted < 1000 && cyc < 20000) begin
                tick();
                cyc++;
            end
        end
        check("rand_count_reached", int'(accepted >= 1000), 1);
        req = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rand_mode = 1'b0;
        ack = 1'b0;
        check("valid_while_idle", viol, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
